pim_bus_arbiter: RTL and testbench
==================================

Name: pim_bus_arbiter

Overview:
- Arbitrates the shared PIM system bus between NUM_REQ bus_interface requesters.
- Consumes each requester's bus_req and bus_op_done, and returns a one-hot bus_grant.
- Grant is held for the owner's full transaction (through its op-done pulse), then a one-cycle turnaround, then round-robin re-arbitration.
- A watchdog revokes grants held too long and latches an error.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- MAX_HOLD_CYCLES, 256: watchdog limit, in cycles a single grant may be held; 0 disables the watchdog.
- ID_W, $clog2(NUM_REQ): requester index width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bus_req  in  NUM_REQ  per-requester bus request (level, held until granted).
- bus_op_done  in  NUM_REQ  per-requester single-cycle transaction-complete pulse.
- err_clr  in  1  clears timeout_err/timeout_id.
- bus_grant  out  NUM_REQ  one-hot grant, registered.
- grant_active  out  1  OR of bus_grant.
- grant_id  out  ID_W  index of current owner; valid only while grant_active.
- timeout_err  out  1  sticky watchdog error.
- timeout_id  out  ID_W  requester revoked by the most recent watchdog expiry.

Behaviour:
- Reset (async assert): bus_grant=0, grant_active=0, grant_id=0, timeout_err=0, timeout_id=0, rr_ptr=0, hold_cnt=0, state=IDLE.
- Reset asserted mid-grant drops the grant immediately, with no completion handshake.
- State machine, 2-bit encoding: IDLE, GRANTED, RELEASE.
- IDLE:
  - If bus_req != 0, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - At the next edge: bus_grant=onehot(winner), grant_id=winner, hold_cnt=0, state -> GRANTED.
  - Latency: request sampled at edge t produces grant visible after edge t+1. No grant issued in the sampling cycle.
  - If bus_req == 0, stay IDLE; outputs unchanged (grant=0).
- GRANTED:
  - hold_cnt increments each cycle, saturating at MAX_HOLD_CYCLES.
  - bus_req of the owner may deassert (the requester drops it while transferring); this does NOT release the grant.
  - bus_op_done[grant_id]=1 -> at the next edge bus_grant=0, state -> RELEASE.
  - bus_op_done from a non-owner is ignored, with no side effects.
  - Watchdog: MAX_HOLD_CYCLES != 0 and hold_cnt == MAX_HOLD_CYCLES-1 with no owner done -> at the next edge bus_grant=0, timeout_err=1, timeout_id=grant_id, state -> RELEASE.
  - Owner done and watchdog expiry in the same cycle: treated as done; no error.
- RELEASE:
  - Exactly one dead cycle with grant=0 (bus turnaround).
  - rr_ptr = (owner+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0. State -> IDLE.
  - Back-to-back requests therefore see a minimum grant-to-grant gap of: tenure + 2 cycles.
- err_clr=1 clears timeout_err and timeout_id at the next edge.
  - A watchdog expiry in the same cycle as err_clr wins: the error is set.
- grant_id and bus_grant always agree: grant_id is held at its last value while grant is 0.
- Invariant: $onehot0(bus_grant) in every cycle; the bench asserts this.

Optional Feature:
- Macro PIM_ARB_HOST_PRIORITY_EN.
- Defined: requester 0 (host/command port) has absolute priority in IDLE. If bus_req[0]=1 it wins regardless of rr_ptr. rr_ptr is not advanced after a requester-0 tenure, so rotation among 1..NUM_REQ-1 stays fair. The watchdog still applies to requester 0.
- Undefined: pure round-robin for all requesters, as described above.

Test Plan:
- Reset, then bus_req=4'b0010 → bus_grant=4'b0010 two edges later, grant_id=1. Pulse bus_op_done[1] → grant=0 next edge, one dead cycle, rr_ptr=2.
- bus_req=4'b1111 held, each owner pulses done 3 cycles after grant → grant order 0,1,2,3,0. Grant-to-grant spacing exactly 5 cycles. Never two bits set.
- Owner 2 granted, bus_op_done[0] and bus_op_done[3] pulsed → grant to 2 unchanged, no state change.
- MAX_HOLD_CYCLES=8, owner 1 never asserts done → grant drops after 8 granted cycles, timeout_err=1, timeout_id=1. Next requester then granted. err_clr → timeout_err=0.
- Owner done on the same cycle as watchdog expiry (MAX_HOLD_CYCLES=8, done on the 8th granted cycle) → timeout_err stays 0. Then assert rst_n=0 mid-grant → bus_grant=0 asynchronously, rr_ptr=0.
- PIM_ARB_HOST_PRIORITY_EN defined, bus_req=4'b1110, then bus_req[0] raised during owner 1's tenure → requester 0 granted next, then 2 (not 1 again), then 3.

Source files
------------

// File: rtl/pim_bus_arbiter.sv
// Round-robin arbiter for the shared PIM system bus, with a hold-time watchdog.
// Optional macro PIM_ARB_HOST_PRIORITY_EN gives requester 0 absolute priority.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; arbitrate over the registered requests
// GRANTED | one owner holds the bus until its op-done pulse or watchdog
// RELEASE | one dead turnaround cycle; advance the round-robin pointer
module pim_bus_arbiter #(
  parameter  int NUM_REQ         = 4,
  parameter  int MAX_HOLD_CYCLES = 256,
  localparam int ID_W            = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] bus_req,
  input  logic [NUM_REQ-1:0] bus_op_done,
  input  logic               err_clr,
  output logic [NUM_REQ-1:0] bus_grant,
  output logic               grant_active,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout_err,
  output logic [ID_W-1:0]    timeout_id
);

  localparam int HOLD_W = (MAX_HOLD_CYCLES < 2) ? 1 : $clog2(MAX_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD_CYCLES == 0) ? '0 : HOLD_W'(MAX_HOLD_CYCLES - 1);
  localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_REQ-1:0] req_q;
  logic [ID_W-1:0]    rr_ptr;
  logic [HOLD_W-1:0]  hold_cnt;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic               owner_done;
  logic               wd_expire;
  logic [ID_W-1:0]    next_ptr;

  // Requests are registered first, so arbitration runs one cycle after sampling.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
`ifdef PIM_ARB_HOST_PRIORITY_EN
    if (req_q[0]) begin
      win_found = 1'b1;
      win_id    = '0;
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!win_found && req_q[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign owner_done = bus_op_done[grant_id];
  assign wd_expire  = (MAX_HOLD_CYCLES != 0) && (hold_cnt == HOLD_LAST);

  always_comb begin
    next_ptr = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
`ifdef PIM_ARB_HOST_PRIORITY_EN
    // Host tenures do not disturb the rotation among the other requesters.
    if (grant_id == '0) next_ptr = rr_ptr;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_q       <= '0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      bus_grant   <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      timeout_id  <= '0;
    end else begin
      req_q <= bus_req;
      // A same-cycle watchdog expiry below overrides this clear.
      if (err_clr) begin
        timeout_err <= 1'b0;
        timeout_id  <= '0;
      end
      case (state)
        IDLE: begin
          if (win_found) begin
            bus_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
            grant_id  <= win_id;
            hold_cnt  <= '0;
            state     <= GRANTED;
          end
        end
        GRANTED: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
          if (owner_done) begin
            bus_grant <= '0;
            state     <= RELEASE;
          end else if (wd_expire) begin
            bus_grant   <= '0;
            timeout_err <= 1'b1;
            timeout_id  <= grant_id;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_active = |bus_grant;

endmodule

// File: tb/tb_pim_bus_arbiter.sv
// Directed self-checking bench for pim_bus_arbiter (NUM_REQ=4, MAX_HOLD_CYCLES=8).
// Host-priority checks run only when PIM_ARB_HOST_PRIORITY_EN is defined.
module tb_pim_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] bus_req;
  logic [3:0] bus_op_done;
  logic       err_clr;
  logic [3:0] bus_grant;
  logic       grant_active;
  logic [1:0] grant_id;
  logic       timeout_err;
  logic [1:0] timeout_id;

  int n_tests = 0;
  int n_fail  = 0;

  pim_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_req      (bus_req),
    .bus_op_done  (bus_op_done),
    .err_clr      (err_clr),
    .bus_grant    (bus_grant),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err),
    .timeout_id   (timeout_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] id);
    check({tag, "_grant"}, 32'(bus_grant), 32'(g));
    check({tag, "_active"}, 32'(grant_active), 32'(|g));
    if (g != 4'b0000) check({tag, "_id"}, 32'(grant_id), 32'(id));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) check("onehot0", 32'($onehot0(bus_grant)), 32'd1);
  end

  initial begin
    rst_n       = 1'b0;
    bus_req     = '0;
    bus_op_done = '0;
    err_clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_grant("rst", 4'b0000, 2'd0);
    check("rst_id", 32'(grant_id), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_tid", 32'(timeout_id), 32'd0);
    check("rst_ptr", 32'(dut.rr_ptr), 32'd0);
    #3 rst_n = 1'b1;
    step();

    // single request: two-edge latency, done, one dead cycle
    bus_req = 4'b0010;
    step();
    check_grant("single_lat", 4'b0000, 2'd0);
    step();
    check_grant("single_gnt", 4'b0010, 2'd1);
    bus_req     = 4'b0000;
    bus_op_done = 4'b0010;
    step();
    bus_op_done = 4'b0000;
    check_grant("single_rel", 4'b0000, 2'd0);
    step();
    check_grant("single_dead", 4'b0000, 2'd0);
    check("single_ptr", 32'(dut.rr_ptr), 32'd2);

`ifndef PIM_ARB_HOST_PRIORITY_EN
    // all four requesting: order 0,1,2,3,0 with 5-cycle spacing
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    bus_req = 4'b1111;
    step();
    step();
    for (int n = 0; n < 4; n++) begin
      check_grant("rr_gnt", 4'b0001 << n, 2'(n));
      step();
      check_grant("rr_hold", 4'b0001 << n, 2'(n));
      step();
      bus_op_done = 4'b0001 << n;
      step();
      bus_op_done = 4'b0000;
      check_grant("rr_rel", 4'b0000, 2'd0);
      step();
      check_grant("rr_dead", 4'b0000, 2'd0);
      step();
    end
    check_grant("rr_wrap", 4'b0001, 2'd0);
    step();
    step();
    bus_op_done = 4'b0001;
    bus_req     = 4'b0000;
    step();
    bus_op_done = 4'b0000;
    check_grant("rr_wrap_rel", 4'b0000, 2'd0);
    step();
    check("rr_ptr", 32'(dut.rr_ptr), 32'd1);

    // non-owner done pulses are ignored
    bus_req = 4'b0100;
    step();
    step();
    check_grant("ign_gnt", 4'b0100, 2'd2);
    bus_req     = 4'b0000;
    bus_op_done = 4'b1001;
    step();
    bus_op_done = 4'b0000;
    check_grant("ign_hold1", 4'b0100, 2'd2);
    step();
    check_grant("ign_hold2", 4'b0100, 2'd2);
    bus_op_done = 4'b0100;
    step();
    bus_op_done = 4'b0000;
    check_grant("ign_rel", 4'b0000, 2'd0);
    step();
    check("ign_ptr", 32'(dut.rr_ptr), 32'd3);
`else
    step();
    step();
    check("pre_wd_ptr", 32'(dut.rr_ptr), 32'd2);
`endif

    // watchdog: owner 1 never finishes, grant lasts exactly 8 cycles
    bus_req = 4'b0010;
    step();
    step();
    check_grant("wd_gnt", 4'b0010, 2'd1);
    bus_req = 4'b0100;
    for (int k = 1; k < 8; k++) begin
      step();
      check_grant("wd_hold", 4'b0010, 2'd1);
    end
    check("wd_err_pre", 32'(timeout_err), 32'd0);
    step();
    check_grant("wd_drop", 4'b0000, 2'd0);
    check("wd_err", 32'(timeout_err), 32'd1);
    check("wd_tid", 32'(timeout_id), 32'd1);
    step();
    check("wd_ptr", 32'(dut.rr_ptr), 32'd2);
    step();
    check_grant("wd_next", 4'b0100, 2'd2);
    bus_req     = 4'b0000;
    bus_op_done = 4'b0100;
    err_clr     = 1'b1;
    step();
    bus_op_done = 4'b0000;
    err_clr     = 1'b0;
    check("clr_err", 32'(timeout_err), 32'd0);
    check("clr_tid", 32'(timeout_id), 32'd0);
    step();
    check("clr_ptr", 32'(dut.rr_ptr), 32'd3);

    // done on the 8th granted cycle beats the watchdog
    bus_req = 4'b0100;
    step();
    step();
    check_grant("tie_gnt", 4'b0100, 2'd2);
    bus_req = 4'b0000;
    for (int k = 1; k < 8; k++) step();
    check_grant("tie_last", 4'b0100, 2'd2);
    bus_op_done = 4'b0100;
    step();
    bus_op_done = 4'b0000;
    check_grant("tie_rel", 4'b0000, 2'd0);
    check("tie_err", 32'(timeout_err), 32'd0);
    step();
    check("tie_ptr", 32'(dut.rr_ptr), 32'd3);

    // asynchronous reset in the middle of a tenure
    bus_req = 4'b0001;
    step();
    step();
    check_grant("ar_gnt", 4'b0001, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    check_grant("ar_drop", 4'b0000, 2'd0);
    check("ar_ptr", 32'(dut.rr_ptr), 32'd0);
    bus_req = 4'b0000;
    #3 rst_n = 1'b1;
    step();

`ifdef PIM_ARB_HOST_PRIORITY_EN
    // host priority: 1, then 0 pre-empts the rotation, then 2, then 3
    bus_req = 4'b1110;
    step();
    step();
    check_grant("hp_g1", 4'b0010, 2'd1);
    bus_req = 4'b1111;
    step();
    bus_req     = 4'b1101;
    bus_op_done = 4'b0010;
    step();
    bus_op_done = 4'b0000;
    check_grant("hp_rel1", 4'b0000, 2'd0);
    step();
    step();
    check_grant("hp_g0", 4'b0001, 2'd0);
    bus_req     = 4'b1100;
    bus_op_done = 4'b0001;
    step();
    bus_op_done = 4'b0000;
    step();
    check("hp_ptr", 32'(dut.rr_ptr), 32'd2);
    step();
    check_grant("hp_g2", 4'b0100, 2'd2);
    bus_req     = 4'b1000;
    bus_op_done = 4'b0100;
    step();
    bus_op_done = 4'b0000;
    step();
    step();
    check_grant("hp_g3", 4'b1000, 2'd3);
    bus_req     = 4'b0000;
    bus_op_done = 4'b1000;
    step();
    bus_op_done = 4'b0000;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
